// File: rtl/cpu_defs.sv
// Shared definitions for the 19-bit single-cycle core: PC width, opcode
// patterns for JSB/RET and the pc_mux select encodings.
package cpu_defs;
  localparam int ADDR_W = 12;

  localparam logic [4:0] JSB = 5'b11101;   // instr[18:14]
  localparam logic [5:0] RET = 6'b111100;  // instr[18:13]

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_mux_e;
endpackage

// File: rtl/stack_regfile.sv
// DEPTH x ADDR_W storage for the return stack: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module stack_regfile #(
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int DEPTH  = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PW-1:0]     i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [PW-1:0]     i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);
  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack: JSB pushes PC+1, RET reads top_addr the same
// cycle. Circular or discard-on-full behaviour, with sticky error flags.
module return_stack
  import cpu_defs::*;
#(
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int DEPTH  = 8,
  parameter int WRAP   = 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf, r_unf;

  logic [PW-1:0]     w_top_idx, w_ptr_nxt, w_waddr;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_we, w_ovf_ev, w_unf_ev, w_empty, w_full;
  logic [ADDR_W-1:0] w_rdata;

  assign w_top_idx = r_wr_ptr - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));

  // Push+pop is pop-then-push: on a non-empty stack that is a top replace.
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_wr_ptr;
    w_ptr_nxt = r_wr_ptr;
    w_cnt_nxt = r_cnt;
    w_ovf_ev  = 1'b0;
    w_unf_ev  = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (!w_full) begin
          w_we      = 1'b1;
          w_ptr_nxt = r_wr_ptr + PW'(1);
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_ovf_ev = 1'b1;
          if (WRAP != 0) begin
            w_we      = 1'b1;
            w_ptr_nxt = r_wr_ptr + PW'(1);
          end
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_ptr_nxt = w_top_idx;
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_unf_ev = 1'b1;
        end
      end
      2'b11: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_waddr = w_top_idx;
        end else begin
          w_unf_ev  = 1'b1;
          w_ptr_nxt = r_wr_ptr + PW'(1);
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ovf    <= w_ovf_ev | (r_ovf & ~err_clr);
      r_unf    <= w_unf_ev | (r_unf & ~err_clr);
    end
  end

  stack_regfile #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rf (
    .i_clk   (clk),
    .i_we    (w_we & reset),
    .i_waddr (w_waddr),
    .i_wdata (push_addr),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  assign top_addr  = w_empty ? '0 : w_rdata;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_cnt;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: WRAP=1 and WRAP=0 instances share stimulus and are
// compared every cycle against a shifting-array stack model.
module tb_return_stack;
  localparam int AW = 12;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] push_addr = '0;

  logic [AW-1:0] top_o  [2];
  logic [3:0]    cnt_o  [2];
  logic          emp_o  [2], ful_o [2], ovf_o [2], unf_o [2];

  int n_chk = 0;
  int n_fail = 0;

  // model: md[m][0] is the oldest entry, md[m][mn[m]-1] the top
  logic [AW-1:0] md [2][D];
  int            mn [2];
  bit            movf [2], munf [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    return_stack #(.ADDR_W(AW), .DEPTH(D), .WRAP(g)) u_dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop),
      .push_addr(push_addr), .err_clr(err_clr),
      .top_addr(top_o[g]), .empty(emp_o[g]), .full(ful_o[g]),
      .count(cnt_o[g]), .overflow(ovf_o[g]), .underflow(unf_o[g])
    );
  end

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s wrap=%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  task automatic mdl(input int m, input bit ps, pp, input logic [AW-1:0] a, input bit clr, rst);
    bit ov, un;
    ov = 0; un = 0;
    if (!rst) begin
      mn[m] = 0; movf[m] = 0; munf[m] = 0;
    end else begin
      if (ps && pp) begin
        if (mn[m] > 0) md[m][mn[m]-1] = a;
        else begin un = 1; md[m][0] = a; mn[m] = 1; end
      end else if (ps) begin
        if (mn[m] < D) begin md[m][mn[m]] = a; mn[m]++; end
        else begin
          ov = 1;
          if (m == 1) begin
            for (int i = 0; i < D-1; i++) md[m][i] = md[m][i+1];
            md[m][D-1] = a;
          end
        end
      end else if (pp) begin
        if (mn[m] > 0) mn[m]--; else un = 1;
      end
      movf[m] = ov | (movf[m] & !clr);
      munf[m] = un | (munf[m] & !clr);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk("top_addr", m, 32'(top_o[m]), (mn[m] > 0) ? 32'(md[m][mn[m]-1]) : 32'd0);
      chk("count", m, 32'(cnt_o[m]), 32'(mn[m]));
      chk("empty", m, 32'(emp_o[m]), 32'(mn[m] == 0));
      chk("full", m, 32'(ful_o[m]), 32'(mn[m] == D));
      chk("overflow", m, 32'(ovf_o[m]), 32'(movf[m]));
      chk("underflow", m, 32'(unf_o[m]), 32'(munf[m]));
    end
  endtask

  task automatic step(input bit ps, pp, input logic [AW-1:0] a, input bit clr, rst);
    push = ps; pop = pp; push_addr = a; err_clr = clr; reset = rst;
    for (int m = 0; m < 2; m++) mdl(m, ps, pp, a, clr, rst);
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    // reset state
    step(0, 0, '0, 0, 0);
    chk("rst_empty", 1, 32'(emp_o[1]), 32'd1);
    chk("rst_top", 1, 32'(top_o[1]), 32'd0);

    // push three, then pop
    step(1, 0, 12'h010, 0, 1);
    step(1, 0, 12'h020, 0, 1);
    step(1, 0, 12'h030, 0, 1);
    chk("tp1_top", 1, 32'(top_o[1]), 32'h030);
    chk("tp1_cnt", 1, 32'(cnt_o[1]), 32'd3);
    step(0, 1, '0, 0, 1);
    chk("tp1_pop_top", 1, 32'(top_o[1]), 32'h020);

    // simultaneous push/pop replaces the top, no flags
    step(1, 1, 12'h0AA, 0, 1);
    chk("repl_top", 0, 32'(top_o[0]), 32'h0AA);
    chk("repl_cnt", 0, 32'(cnt_o[0]), 32'd2);
    chk("repl_unf", 0, 32'(unf_o[0]), 32'd0);

    // pop on empty, then clear
    step(0, 0, '0, 0, 0);
    step(0, 1, '0, 0, 1);
    chk("unf_set", 1, 32'(unf_o[1]), 32'd1);
    step(0, 0, '0, 1, 1);
    chk("unf_clr", 1, 32'(unf_o[1]), 32'd0);

    // overfill: wrap keeps newest eight, discard keeps 1..8
    step(0, 0, '0, 0, 0);
    for (int i = 1; i <= 9; i++) step(1, 0, 12'(i), 0, 1);
    chk("ovf_w1", 1, 32'(ovf_o[1]), 32'd1);
    chk("ovf_top_w1", 1, 32'(top_o[1]), 32'h009);
    chk("ovf_top_w0", 0, 32'(top_o[0]), 32'h008);
    chk("ovf_full_w0", 0, 32'(ful_o[0]), 32'd1);

    // reset while pushing with count=5, overflow=1
    for (int i = 0; i < 3; i++) step(0, 1, '0, 0, 1);
    chk("pre_rst_cnt", 1, 32'(cnt_o[1]), 32'd5);
    step(1, 0, 12'h777, 0, 0);
    chk("mid_rst_ovf", 1, 32'(ovf_o[1]), 32'd0);
    chk("mid_rst_top", 1, 32'(top_o[1]), 32'd0);

    // refill for the full eight-pop drain
    for (int i = 1; i <= 9; i++) step(1, 0, 12'(i), 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 1);
    chk("drain_empty", 1, 32'(emp_o[1]), 32'd1);

    // push+pop on empty
    step(1, 1, 12'h5A5, 0, 1);
    chk("pp_empty_cnt", 1, 32'(cnt_o[1]), 32'd1);
    chk("pp_empty_unf", 1, 32'(unf_o[1]), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 55 || r >= 85, r >= 45, 12'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
